// File: rtl/freq_pkg.sv
// Shared definitions for the frequency synthesizer and its companion
// frequency counter: default sizes, FSM state encoding, accumulator sizing.
package freq_pkg;

    localparam int FREQ_W_DEF      = 16;
    localparam int GATE_CYCLES_DEF = 100000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // One bit of headroom so acc + 2*F (always < 2*GATE_CYCLES) never overflows.
    function automatic int acc_width(input int gate_cycles);
        return $clog2(gate_cycles) + 1;
    endfunction

endpackage

// File: rtl/freq_synth_nco.sv
// Phase accumulator: adds 2*F per active cycle and toggles sigout each time
// the sum reaches GATE_CYCLES, giving exactly F rising edges per window.
module freq_synth_nco
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int FREQ_W      = FREQ_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              run,
    input  logic [FREQ_W-1:0] f,
    output logic              sigout,
    output logic              rise
);

    localparam int            AW     = acc_width(GATE_CYCLES);
    localparam logic [AW-1:0] GATE_W = AW'(GATE_CYCLES);

    logic [AW-1:0] acc_reg;
    logic [AW-1:0] acc_next;
    logic [AW-1:0] step;
    logic [AW-1:0] sum;
    logic          sig_reg;
    logic          sig_next;

    // f is already clamped to GATE_CYCLES/2, so 2*f always fits in AW bits.
    always_comb begin
        step     = AW'(f) << 1;
        sum      = acc_reg + step;
        acc_next = acc_reg;
        sig_next = sig_reg;
        if (clear) begin
            acc_next = '0;
            sig_next = 1'b0;
        end else if (run) begin
            if (sum >= GATE_W) begin
                acc_next = sum - GATE_W;
                sig_next = ~sig_reg;
            end else begin
                acc_next = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            sig_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            sig_reg <= sig_next;
        end
    end

    assign sigout = sig_reg;
    assign rise   = sig_next & ~sig_reg;

endmodule

// File: rtl/freq_synth.sv
// Frequency synthesizer: control FSM, freq_in handshake with glitch-free
// pending update, gate-window timing and per-window rising-edge count.
module freq_synth
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int FREQ_W      = FREQ_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              freq_valid,
    output logic              freq_ready,
    output logic              sigout,
    output logic [FREQ_W-1:0] edge_cnt,
    output logic              window_done,
    output logic              clamped
);

    localparam int                WW       = acc_width(GATE_CYCLES) - 1;
    localparam logic [WW-1:0]     WIN_LAST = WW'(GATE_CYCLES - 1);
    localparam logic [63:0]       HALF_W   = 64'(GATE_CYCLES / 2);
    localparam logic [FREQ_W-1:0] CNT_MAX  = '1;

    state_t            state_reg;
    state_t            state_next;
    logic [FREQ_W-1:0] f_reg;
    logic [FREQ_W-1:0] f_next;
    logic [FREQ_W-1:0] pend_reg;
    logic [FREQ_W-1:0] pend_next;
    logic              clamped_reg;
    logic              clamped_next;
    logic [WW-1:0]     win_reg;
    logic [FREQ_W-1:0] cnt_reg;
    logic [FREQ_W-1:0] edge_cnt_reg;
    logic              done_reg;

    logic              xfer;
    logic              over;
    logic [FREQ_W-1:0] freq_clamped;
    logic              pend_load;
    logic              active;
    logic              going_idle;
    logic              rise;

    always_comb begin
        over         = 64'(freq_in) > HALF_W;
        freq_clamped = over ? FREQ_W'(HALF_W) : freq_in;
        freq_ready   = (state_reg != ST_PEND);
        xfer         = freq_valid & freq_ready;
        state_next   = state_reg;
        f_next       = f_reg;
        pend_next    = pend_reg;
        clamped_next = clamped_reg;
        pend_load    = 1'b0;

        if (xfer) begin
            clamped_next = over;
        end

        case (state_reg)
            ST_IDLE: begin
                if (xfer) begin
                    f_next = freq_clamped;
                end
                if (enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A word arriving as enable drops is applied directly in IDLE.
                if (!enable) begin
                    state_next = ST_IDLE;
                    if (xfer) begin
                        f_next = freq_clamped;
                    end
                end else if (xfer) begin
                    pend_next  = freq_clamped;
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!enable) begin
                    f_next     = pend_reg;
                    state_next = ST_IDLE;
                end else if (!sigout) begin
                    // Swap only while low so no runt pulse can appear.
                    f_next     = pend_reg;
                    pend_load  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        active     = (state_reg != ST_IDLE);
        going_idle = (state_next == ST_IDLE);
    end

    freq_synth_nco #(
        .GATE_CYCLES (GATE_CYCLES),
        .FREQ_W      (FREQ_W)
    ) u_nco (
        .clk    (clk),
        .rst    (rst),
        .clear  (going_idle | pend_load),
        .run    (active),
        .f      (f_reg),
        .sigout (sigout),
        .rise   (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            f_reg        <= '0;
            pend_reg     <= '0;
            clamped_reg  <= 1'b0;
            win_reg      <= '0;
            cnt_reg      <= '0;
            edge_cnt_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            f_reg       <= f_next;
            pend_reg    <= pend_next;
            clamped_reg <= clamped_next;
            done_reg    <= 1'b0;
            if (going_idle) begin
                win_reg <= '0;
                cnt_reg <= '0;
            end else if (active) begin
                // A rise landing on the wrap edge belongs to the new window.
                if (win_reg == WIN_LAST) begin
                    win_reg      <= '0;
                    done_reg     <= 1'b1;
                    edge_cnt_reg <= cnt_reg;
                    cnt_reg      <= FREQ_W'(rise);
                end else begin
                    win_reg <= win_reg + WW'(1);
                    if (rise && (cnt_reg != CNT_MAX)) begin
                        cnt_reg <= cnt_reg + FREQ_W'(1);
                    end
                end
            end
        end
    end

    assign edge_cnt    = edge_cnt_reg;
    assign window_done = done_reg;
    assign clamped     = clamped_reg;

endmodule
